// File: rtl/regwb_pkg.sv
// regwb_pkg
// Shared types and constants for the register-file write-back arbiter.
//   NUM_REQ   : number of write requesters (ALU, MEM, IO)
//   REG_W     : register data width
//   DR_W      : destination-register index width
//   NUM_REGS  : number of architectural registers (scoreboard width)
//   src_id_t  : requester identity; SRC_NONE marks an empty output stage
//   wb_entry_t: one staged register-file write
package regwb_pkg;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned REG_W    = 16;
    localparam int unsigned DR_W     = 3;
    localparam int unsigned NUM_REGS = 8;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_IO   = 2'd2,
        SRC_NONE = 2'd3
    } src_id_t;

    typedef struct packed {
        logic            valid;
        logic [DR_W-1:0] dr;
        logic [REG_W-1:0] data;
        src_id_t         src;
    } wb_entry_t;

    // (a + b) mod 3 for operands in 0..2.
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Round-robin pointer after granting requester idx.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return add_mod3(idx, 2'd1);
    endfunction

endpackage

// File: rtl/regwb_arbiter_rr_pick3.sv
// rr_pick3
// Combinational three-way round-robin selector.
//   valid_i : per-requester request bits
//   ptr_i   : requester with highest priority this cycle (3 is treated as 0)
//   grant_o : one-hot grant of the first valid requester at or after ptr_i
//   idx_o   : index of the granted requester, 2'd3 when nothing is valid
module rr_pick3
    import regwb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [1:0]         idx_o
);

    logic [1:0]         start;
    logic [NUM_REQ-1:0] rot;
    logic [1:0]         offset;
    logic               any;

    always_comb begin
        start = (ptr_i == 2'd3) ? 2'd0 : ptr_i;

        // rot[i] is the request of requester (start + i) mod 3.
        unique case (start)
            2'd1:    rot = {valid_i[0], valid_i[2], valid_i[1]};
            2'd2:    rot = {valid_i[1], valid_i[0], valid_i[2]};
            default: rot = valid_i;
        endcase

        any    = |rot;
        offset = 2'd0;
        if (rot[0]) begin
            offset = 2'd0;
        end else if (rot[1]) begin
            offset = 2'd1;
        end else if (rot[2]) begin
            offset = 2'd2;
        end

        grant_o = '0;
        idx_o   = 2'd3;
        if (any) begin
            idx_o   = add_mod3(start, offset);
            grant_o = 3'b001 << idx_o;
        end
    end

endmodule

// File: rtl/regwb_arbiter.sv
// regwb_arbiter
// Arbitrates three register-file write requesters (ALU, MEM, IO) onto a single
// write port through a one-entry output stage, with round-robin fairness.
// Optional feature macro: REGWB_SCOREBOARD_EN enables the busy scoreboard;
// when undefined, busy is tied to zero and no scoreboard flops are built.
//
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset
//   req_valid     : per-requester write request
//   req_dr        : packed destination registers, requester k at [3k+2:3k]
//   req_data      : packed write data, requester k at [16k+15:16k]
//   req_ready     : one-hot grant (accept = valid & ready at posedge)
//   wb_stall      : blocks issue to the register file and new grants
//   LD_REG        : register-file write enable
//   DRMUX_output  : register-file write address
//   data_in       : register-file write data
//   grant_id      : source of the staged write, 2'd3 when the stage is empty
//   busy          : per-register pending-write scoreboard
module regwb_arbiter
    import regwb_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DR_W-1:0]  req_dr,
    input  logic [NUM_REQ*REG_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     wb_stall,
    output logic                     LD_REG,
    output logic [DR_W-1:0]          DRMUX_output,
    output logic [REG_W-1:0]         data_in,
    output logic [1:0]               grant_id,
    output logic [NUM_REGS-1:0]      busy
);

    wb_entry_t          out_q, out_d;
    logic [1:0]         rr_q, rr_d;
    logic [NUM_REQ-1:0] pick_grant;
    logic [1:0]         pick_idx;
    logic               issue;
    logic               grant_ok;
    logic               accept;
    logic [DR_W-1:0]    sel_dr;
    logic [REG_W-1:0]   sel_data;

    rr_pick3 u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Reset suppresses the write so a pending entry is discarded, not issued.
    assign issue    = out_q.valid & ~wb_stall & ~Reset;
    // The stage can take a new write when empty or draining this cycle.
    assign grant_ok = ~Reset & ~wb_stall & (~out_q.valid | issue);
    assign accept   = grant_ok & (|pick_grant);

    assign req_ready    = grant_ok ? pick_grant : '0;
    assign LD_REG       = issue;
    assign DRMUX_output = out_q.dr;
    assign data_in      = out_q.data;
    assign grant_id     = out_q.valid ? 2'(out_q.src) : 2'(SRC_NONE);

    always_comb begin
        unique case (pick_idx)
            2'd1: begin
                sel_dr   = req_dr[2*DR_W-1:DR_W];
                sel_data = req_data[2*REG_W-1:REG_W];
            end
            2'd2: begin
                sel_dr   = req_dr[3*DR_W-1:2*DR_W];
                sel_data = req_data[3*REG_W-1:2*REG_W];
            end
            default: begin
                sel_dr   = req_dr[DR_W-1:0];
                sel_data = req_data[REG_W-1:0];
            end
        endcase
    end

    always_comb begin
        out_d = out_q;
        rr_d  = rr_q;
        if (accept) begin
            out_d.valid = 1'b1;
            out_d.dr    = sel_dr;
            out_d.data  = sel_data;
            out_d.src   = src_id_t'(pick_idx);
            rr_d        = next_ptr(pick_idx);
        end else if (issue) begin
            out_d.valid = 1'b0;
            out_d.src   = SRC_NONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_q <= '{valid: 1'b0, dr: '0, data: '0, src: SRC_NONE};
            rr_q  <= 2'd0;
        end else begin
            out_q <= out_d;
            rr_q  <= rr_d;
        end
    end

`ifdef REGWB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Set after clear so a same-register accept wins over the issue.
    always_comb begin
        busy_d = busy_q;
        if (issue) begin
            busy_d[out_q.dr] = 1'b0;
        end
        if (accept) begin
            busy_d[sel_dr] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    assign busy = '0;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter
// Directed and randomized checks of regwb_arbiter against a behavioural model:
// the model keeps the pending write as a simple record, picks grants by
// scanning requesters in round-robin order, and mirrors the register file.
module tb_regwb_arbiter;

    logic        Clk;
    logic        Reset;
    logic [2:0]  req_valid;
    logic [8:0]  req_dr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_stall;
    logic        LD_REG;
    logic [2:0]  DRMUX_output;
    logic [15:0] data_in;
    logic [1:0]  grant_id;
    logic [7:0]  busy;

`ifdef REGWB_SCOREBOARD_EN
    localparam logic [7:0] BUSY4 = 8'h10;
`else
    localparam logic [7:0] BUSY4 = 8'h00;
`endif

    regwb_arbiter dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_dr       (req_dr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_stall     (wb_stall),
        .LD_REG       (LD_REG),
        .DRMUX_output (DRMUX_output),
        .data_in      (data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp;
    int n_fail;

    // Behavioural model state.
    logic        m_valid;
    logic [2:0]  m_dr;
    logic [15:0] m_data;
    int          m_src;
    int          m_ptr;
    logic [15:0] m_rf   [8];
    logic [15:0] dut_rf [8];

    // Last sampled DUT outputs.
    logic [2:0]  obs_ready;
    logic        obs_ld;
    logic [2:0]  obs_dr;
    logic [15:0] obs_data;
    logic [1:0]  obs_gid;
    logic [7:0]  obs_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [2:0] dr, input logic [15:0] data);
        req_dr[3*k +: 3]    = dr;
        req_data[16*k +: 16] = data;
    endtask

    // One clock: drive inputs, check outputs against the model, advance both.
    task automatic step(input logic rst, input logic [2:0] v, input logic stall);
        logic [2:0] exp_ready;
        logic       exp_ld;
        logic [7:0] exp_busy;
        int         k;
        int         j;
        Reset     = rst;
        req_valid = v;
        wb_stall  = stall;
        #1;
        obs_ready = req_ready;
        obs_ld    = LD_REG;
        obs_dr    = DRMUX_output;
        obs_data  = data_in;
        obs_gid   = grant_id;
        obs_busy  = busy;

        k = -1;
        if (!rst && !stall) begin
            for (int off = 0; off < 3; off++) begin
                j = (m_ptr + off) % 3;
                if (k < 0 && ((v >> j) & 3'b001) != 3'b000) k = j;
            end
        end
        exp_ready = (k >= 0) ? 3'(1 << k) : 3'b000;
        exp_ld    = !rst && m_valid && !stall;
`ifdef REGWB_SCOREBOARD_EN
        exp_busy  = m_valid ? 8'(1 << m_dr) : 8'h00;
`else
        exp_busy  = 8'h00;
`endif
        chk("req_ready", 32'(obs_ready), 32'(exp_ready));
        chk("ld_reg", 32'(obs_ld), 32'(exp_ld));
        chk("grant_id", 32'(obs_gid), m_valid ? 32'(m_src) : 32'd3);
        chk("busy", 32'(obs_busy), 32'(exp_busy));
        if (m_valid) begin
            chk("wr_addr", 32'(obs_dr), 32'(m_dr));
            chk("wr_data", 32'(obs_data), 32'(m_data));
        end
        if (obs_ld) dut_rf[obs_dr] = obs_data;

        @(posedge Clk);
        if (exp_ld) m_rf[m_dr] = m_data;
        if (rst) begin
            m_valid = 1'b0;
            m_dr    = '0;
            m_data  = '0;
            m_ptr   = 0;
        end else if (k >= 0) begin
            m_valid = 1'b1;
            m_dr    = req_dr[3*k +: 3];
            m_data  = req_data[16*k +: 16];
            m_src   = k;
            m_ptr   = (k + 1) % 3;
        end else if (exp_ld) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int r = 0; r < 8; r++) begin
            m_rf[r]   = 16'h0000;
            dut_rf[r] = 16'h0000;
        end
        m_valid   = 1'b0;
        m_dr      = '0;
        m_data    = '0;
        m_src     = 3;
        m_ptr     = 0;
        Reset     = 1'b1;
        req_valid = '0;
        wb_stall  = 1'b0;
        req_dr    = '0;
        req_data  = '0;
        @(posedge Clk);
        #1;

        // Reset with all requests asserted: nothing granted, nothing written.
        step(1'b1, 3'b111, 1'b0);
        chk("rst_ready", 32'(obs_ready), 32'd0);
        step(1'b0, 3'b000, 1'b0);
        chk("rst_ld", 32'(obs_ld), 32'd0);
        chk("rst_gid", 32'(obs_gid), 32'd3);
        chk("rst_addr", 32'(obs_dr), 32'd0);
        chk("rst_data", 32'(obs_data), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);

        // All three held valid: grants 0,1,2 and writes R1,R2,R3 back to back.
        set_req(0, 3'd1, 16'hA001);
        set_req(1, 3'd2, 16'hB002);
        set_req(2, 3'd3, 16'hC003);
        step(1'b0, 3'b111, 1'b0);
        chk("rr_g0", 32'(obs_ready), 32'b001);
        step(1'b0, 3'b111, 1'b0);
        chk("rr_g1", 32'(obs_ready), 32'b010);
        chk("rr_w1", {15'd0, obs_ld, 13'd0, obs_dr}, {15'd0, 1'b1, 13'd0, 3'd1});
        chk("rr_d1", 32'(obs_data), 32'hA001);
        step(1'b0, 3'b111, 1'b0);
        chk("rr_g2", 32'(obs_ready), 32'b100);
        chk("rr_w2", {15'd0, obs_ld, 13'd0, obs_dr}, {15'd0, 1'b1, 13'd0, 3'd2});
        step(1'b0, 3'b000, 1'b0);
        chk("rr_w3", {15'd0, obs_ld, 13'd0, obs_dr}, {15'd0, 1'b1, 13'd0, 3'd3});
        chk("rr_d3", 32'(obs_data), 32'hC003);
        step(1'b0, 3'b000, 1'b0);
        chk("idle_gid", 32'(obs_gid), 32'd3);

        // Single MEM request.
        set_req(1, 3'd5, 16'h1234);
        step(1'b0, 3'b010, 1'b0);
        chk("mem_ready", 32'(obs_ready), 32'b010);
        step(1'b0, 3'b000, 1'b0);
        chk("mem_ld", 32'(obs_ld), 32'd1);
        chk("mem_addr", 32'(obs_dr), 32'd5);
        chk("mem_data", 32'(obs_data), 32'h1234);
        chk("mem_gid", 32'(obs_gid), 32'd1);

        // Pointer now at 2: IO wins, ALU follows, ALU data is final in R7.
        set_req(0, 3'd7, 16'h0001);
        set_req(2, 3'd7, 16'h0002);
        step(1'b0, 3'b101, 1'b0);
        chk("same_first", 32'(obs_ready), 32'b100);
        step(1'b0, 3'b001, 1'b0);
        chk("same_second", 32'(obs_ready), 32'b001);
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        chk("r7_final", 32'(dut_rf[7]), 32'h0001);

        // Stall holds the staged write for three cycles.
        set_req(0, 3'd6, 16'h5A5A);
        step(1'b0, 3'b001, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 3'b111, 1'b1);
            chk("stall_ready", 32'(obs_ready), 32'd0);
            chk("stall_ld", 32'(obs_ld), 32'd0);
            chk("stall_hold", {13'd0, obs_dr, obs_data}, {13'd0, 3'd6, 16'h5A5A});
        end
        step(1'b0, 3'b000, 1'b0);
        chk("unstall_ld", 32'(obs_ld), 32'd1);
        chk("unstall_addr", 32'(obs_dr), 32'd6);

        // Back-to-back writes to R4 keep busy[4] set until the second issues.
        set_req(1, 3'd4, 16'h4444);
        step(1'b0, 3'b010, 1'b0);
        set_req(2, 3'd4, 16'h4445);
        step(1'b0, 3'b100, 1'b0);
        chk("sb_busy1", 32'(obs_busy), 32'(BUSY4));
        step(1'b0, 3'b000, 1'b0);
        chk("sb_busy2", 32'(obs_busy), 32'(BUSY4));
        chk("sb_data2", 32'(obs_data), 32'h4445);
        step(1'b0, 3'b000, 1'b0);
        chk("sb_clear", 32'(obs_busy), 32'd0);

        // Reset over a stalled pending write: discarded, pointer back to 0.
        set_req(1, 3'd3, 16'h7777);
        step(1'b0, 3'b010, 1'b0);
        step(1'b0, 3'b000, 1'b1);
        chk("pre_rst_gid", 32'(obs_gid), 32'd1);
        step(1'b1, 3'b000, 1'b1);
        chk("rst_ld_pend", 32'(obs_ld), 32'd0);
        set_req(0, 3'd0, 16'h0F0F);
        step(1'b0, 3'b111, 1'b0);
        chk("post_rst_gid", 32'(obs_gid), 32'd3);
        chk("post_rst_ready", 32'(obs_ready), 32'b001);
        step(1'b0, 3'b000, 1'b0);
        chk("r3_kept", 32'(dut_rf[3]), 32'hC003);

        // Randomized traffic with occasional stalls and resets.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                set_req(k, 3'($urandom_range(0, 7)), 16'($urandom));
            end
            step($urandom_range(0, 49) == 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) == 0);
        end
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);

        for (int r = 0; r < 8; r++) begin
            chk($sformatf("rf%0d", r), 32'(dut_rf[r]), 32'(m_rf[r]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
